serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial, LSB-first N-bit adder; the additive counterpart to the team's subtractor cells.
- Accepts two operands and a carry-in on a start strobe.
- Processes one bit per clock through a single 1-bit full adder and a carry flip-flop.
- Presents the registered sum, carry-out and a one-cycle done pulse.
- Used where area matters more than latency, e.g. accumulators in slow control paths.

Parameters:
- WIDTH, 8, operand and sum width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is updated.
- sum  output  WIDTH  result a+b+cin mod 2^WIDTH, registered.
- cout  output  1  carry out of the MSB, registered.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flip-flop and bit counter are cleared.
  - Reset mid-RUN abandons the operation; no done pulse is produced.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge E0 loads a, b into shift registers, cin into the carry flip-flop, and sets counter=0.
  - busy=1 from E0; go to RUN.
  - start=0 keeps the block in IDLE; outputs hold.
- RUN, at each edge Ei (i=1..WIDTH):
  - s = a_sr[0] ^ b_sr[0] ^ c.
  - c <= majority(a_sr[0], b_sr[0], c).
  - a_sr, b_sr shift right.
  - s enters the result shift register at the MSB end.
  - counter increments.
- At edge E(WIDTH) (last bit):
  - sum <= completed result register; cout <= final carry.
  - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: done is high in the cycle following E(WIDTH), i.e. WIDTH cycles after the accepting edge.
- Throughput: one operation per WIDTH+1 cycles.
- start while busy=1 is ignored; operands are not re-captured and no error is flagged.
- start high during the done cycle is accepted at the next edge (back-to-back operation).
- sum/cout change only at completion. They are stable during RUN (previous result) and hold until the next completion.
- Counter width is clog2(WIDTH)+1. Terminal count is WIDTH-1 before increment.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output ovf (1 bit), registered with sum.
  - ovf = carry into MSB XOR carry out of MSB (two's-complement overflow).
  - Reset value 0.
- Undefined: no ovf port and no related logic.

Decomposition:
- Package serial_adder_pkg holds:
  - the state enum (IDLE, RUN);
  - a localparam function for the counter width (clog2(WIDTH)+1).
- Sub-module full_adder: combinational 1-bit cell, inputs x, y, ci, outputs s, co. Instantiated once.

Test Plan:
- Reset mid-RUN: start a=8'h35, b=8'h1A, then rst_n=0 at cycle 3 -> busy, done, sum, cout read 0 asynchronously; no done pulse after release.
- Basic add: a=8'h35, b=8'h1A, cin=0 -> done exactly 8 cycles after accept; sum=8'h4F, cout=0; ovf=0.
- Carry chain:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0.
  - a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
- Signed overflow: a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1 (macro defined); no ovf port when undefined.
- Busy ignore: accept a=8'h10, b=8'h20, then pulse start with a=8'hAA, b=8'h55 at cycle 4 -> result sum=8'h30; single done pulse.
- Back-to-back: start held during the done cycle with a=8'h01, b=8'h02 -> accepted next edge; second done 9 cycles after the first; sum=8'h03; first result held until then.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Optional two's-complement overflow output is enabled by SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Bit counter width: clog2(width)+1
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Combinational 1-bit full adder cell used by the serial adder datapath.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first WIDTH-bit adder: one full adder plus a carry flip-flop.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_full;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             bit_co;

  full_adder u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (bit_s),
    .co (bit_co)
  );

  // Only WIDTH-1 bits are stored; the final bit joins them directly into sum.
  assign res_full = {bit_s, res_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= last;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        carry  <= bit_co;
        res_sr <= res_full[WIDTH-1:1];
        cnt    <= cnt + CW'(1);
        if (last) begin
          sum  <= res_full;
          cout <= bit_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry still holds the carry into the MSB here
          ovf  <= carry ^ bit_co;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands vs arithmetic model.
// Covers ovf when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf  = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned and signed arithmetic on the operands.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int unsigned total;
    int          sx;
    int          sy;
    int          ss;
    total    = x + y + ci;
    exp_sum  = W'(total);
    exp_cout = ((total >> W) & 1) != 0;
    sx       = $signed(x);
    sy       = $signed(y);
    ss       = sx + sy + int'(ci);
    exp_ovf  = (ss > (2 ** (W - 1)) - 1) || (ss < -(2 ** (W - 1)));
  endtask

  task automatic accept(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci);
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Waits (bounded) for done; sum must keep the previous result meanwhile.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    for (int n = 1; n <= 3 * W; n++) begin
      step();
      if (done) begin
        lat = n;
        return;
      end
      check({tag, "_hold"}, 32'(sum), 32'(exp_sum));
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic ci);
    model(x, y, ci);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci);
    int lat;
    accept(tag, x, y, ci);
    wait_done(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check_result(tag, x, y, ci);
    step();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    // Reset state
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    step();

    // Non-zero result first so the async reset has something to clear
    full_op("pre", 8'hC3, 8'h5A, 1'b1);

    // Reset mid-run
    accept("midrst", 8'h35, 8'h1A, 1'b0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("midrst_ovf", 32'(ovf), 32'd0);
`endif
    exp_sum  = '0;
    exp_cout = 1'b0;
    step();
    rst_n  = 1'b1;
    pulses = 0;
    for (int n = 0; n < 2 * W; n++) begin
      step();
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    // Directed arithmetic cases
    full_op("basic", 8'h35, 8'h1A, 1'b0);
    full_op("chain1", 8'hFF, 8'h01, 1'b0);
    full_op("chain2", 8'hFF, 8'h00, 1'b1);
    full_op("sovf", 8'h7F, 8'h01, 1'b0);
    full_op("negovf", 8'h80, 8'hFF, 1'b0);

    // Start pulse while busy must be ignored
    accept("ign", 8'h10, 8'h20, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      step();
      check("ign_hold", 32'(sum), 32'(exp_sum));
    end
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    step();
    start = 1'b0;
    wait_done("ign", lat);
    check("ign_latency", 32'(lat + 5), 32'(W));
    check_result("ign", 8'h10, 8'h20, 1'b0);
    step();
    check("ign_done_pulse", 32'(done), 32'd0);
    check("ign_not_queued", 32'(busy), 32'd0);

    // Back-to-back: start held during the done cycle
    rx = W'($urandom);
    ry = W'($urandom);
    accept("b2b1", rx, ry, 1'b0);
    wait_done("b2b1", lat);
    check("b2b1_latency", 32'(lat), 32'(W));
    check_result("b2b1", rx, ry, 1'b0);
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    cin   = 1'b0;
    step();
    start = 1'b0;
    check("b2b2_busy", 32'(busy), 32'd1);
    check("b2b2_done_low", 32'(done), 32'd0);
    wait_done("b2b2", lat);
    check("b2b2_spacing", 32'(lat + 1), 32'(W + 1));
    check_result("b2b2", 8'h01, 8'h02, 1'b0);
    step();
    check("b2b2_done_pulse", 32'(done), 32'd0);

    // Random operands
    for (int i = 0; i < 16; i++) begin
      full_op("rand", W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
